// File: rtl/descrambler_pkg.sv
// Shared definitions for the 4-bit scrambler/descrambler pair.
// The lfsr_step function is the single source of truth for the keystream
// polynomial so transmit and receive sides stay bit-identical.
package descrambler_pkg;

  localparam int LFSR_W = 4;

  // One scrambled or plain data nibble.
  typedef logic [LFSR_W-1:0] nibble_t;

  // Keystream register value after reset; also the first key used.
  localparam nibble_t LFSR_INIT = 4'd1;

  // Advance the keystream by one position.
  // Sequence from 1: 1, 9, D, F, E, 7, ...
  // A state of 0 maps to 0 (lock-up), which the top level flags.
  function automatic nibble_t lfsr_step(input nibble_t r);
    nibble_t nxt;
    if (r[0]) begin
      nxt = {1'b1, r[3:2], ~r[1]};
    end else begin
      nxt = {1'b0, r[3:1]};
    end
    return nxt;
  endfunction

endpackage

// File: rtl/nibble_fifo.sv
// Small synchronous FIFO of nibbles.
// DEPTH must be a power of two and at least 2 so the pointers wrap for
// free. Write and read may happen in the same cycle when neither full nor
// empty blocks them; occupancy is then unchanged. Head is the oldest entry
// straight from the storage array, with no bypass from the write port.
module nibble_fifo
  import descrambler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    enq,
  input  nibble_t data,
  input  logic    deq,
  output logic    full,
  output logic    empty,
  output nibble_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW + 1)'(DEPTH);

  nibble_t        mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    occ;
  logic           do_enq;
  logic           do_deq;

  // Requests are re-qualified here so the FIFO stays safe on its own.
  assign full   = (occ == FULL_OCC);
  assign empty  = (occ == '0);
  assign do_enq = enq & ~full;
  assign do_deq = deq & ~empty;
  assign head   = mem[rd_ptr];

  // Storage write; contents need no reset because occupancy gates reads.
  always_ff @(posedge clk) begin
    if (rst_n && do_enq) begin
      mem[wr_ptr] <= data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_enq) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_deq) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_enq, do_deq})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/nibble_descrambler.sv
// Receive-side descrambler: buffers scrambled nibbles and XORs the head
// with a 4-bit LFSR keystream identical to the transmit side.
// Optional feature macro: DESCRAMBLER_CNT_EN adds an 8-bit saturating
// delivered-nibble counter and its count port.
//
// Handshake: every method has an EN_x input and a RDY_x output. An EN_x
// takes effect on the rising clock edge only when RDY_x is high in that
// same cycle; an EN_x seen while RDY_x is low is silently ignored. RDY_x
// and out depend on registered state only, never on any EN_x.
module nibble_descrambler
  import descrambler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] in_data,
  input  logic       EN_in,
  output logic       RDY_in,
  input  logic [3:0] seed_value,
  input  logic       EN_seed,
  output logic       RDY_seed,
  input  logic       EN_out,
  output logic [3:0] out,
  output logic       RDY_out,
  output logic       seed_err
`ifdef DESCRAMBLER_CNT_EN
  ,
  output logic [7:0] count
`endif
);

  nibble_t lfsr;
  nibble_t head;
  logic    fifo_full;
  logic    fifo_empty;
  logic    do_enq;
  logic    do_deq;
  logic    do_seed;

  // Ready derivation. Seeding is only allowed at a stream boundary so a
  // new key can never apply to nibbles already buffered under the old one.
  assign RDY_in   = ~fifo_full;
  assign RDY_out  = ~fifo_empty;
  assign RDY_seed = fifo_empty;

  assign do_enq  = EN_in   & RDY_in;
  assign do_deq  = EN_out  & RDY_out;
  assign do_seed = EN_seed & RDY_seed;

  // The key for the head nibble is the current lfsr value.
  assign out = RDY_out ? (head ^ lfsr) : 4'd0;

  nibble_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .enq   (do_enq),
    .data  (in_data),
    .deq   (do_deq),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  // Keystream register and sticky lock-up flag; seed wins over stepping.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      lfsr     <= LFSR_INIT;
      seed_err <= 1'b0;
    end else if (do_seed) begin
      lfsr <= seed_value;
      if (seed_value == 4'd0) begin
        seed_err <= 1'b1;
      end
    end else if (do_deq) begin
      lfsr <= lfsr_step(lfsr);
    end
  end

`ifdef DESCRAMBLER_CNT_EN
  // Delivered-nibble counter: saturates at 255, restarts on a new seed.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      count <= 8'd0;
    end else if (do_seed) begin
      count <= 8'd0;
    end else if (do_deq && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end
`else
  // No delivered-nibble counter in this build.
`endif

endmodule

// File: tb/tb_nibble_descrambler.sv
// Self-checking bench for nibble_descrambler (DEPTH = 4).
// Define DESCRAMBLER_CNT_EN to also exercise the count port.
module tb_nibble_descrambler;

  localparam int DEPTH = 4;

  logic       CLK;
  logic       RST_N;
  logic [3:0] in_data;
  logic       EN_in;
  logic       RDY_in;
  logic [3:0] seed_value;
  logic       EN_seed;
  logic       RDY_seed;
  logic       EN_out;
  logic [3:0] out;
  logic       RDY_out;
  logic       seed_err;
`ifdef DESCRAMBLER_CNT_EN
  logic [7:0] count;
`endif

  // Scoreboard and reference model state.
  logic [3:0] exp_q[$];
  logic [3:0] key_m;   // key the next enqueued nibble will be decoded with
  int         occ_m;
  logic       err_m;
  int         cnt_m;
  int         n_checks;
  int         n_pass;

  nibble_descrambler #(
    .DEPTH (DEPTH)
  ) dut (
`ifdef DESCRAMBLER_CNT_EN
    .count      (count),
`endif
    .CLK        (CLK),
    .RST_N      (RST_N),
    .in_data    (in_data),
    .EN_in      (EN_in),
    .RDY_in     (RDY_in),
    .seed_value (seed_value),
    .EN_seed    (EN_seed),
    .RDY_seed   (RDY_seed),
    .EN_out     (EN_out),
    .out        (out),
    .RDY_out    (RDY_out),
    .seed_err   (seed_err)
  );

  // Clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Keystream reference: 1, 9, D, F, E, 7, ...
  function automatic logic [3:0] key_next(input logic [3:0] r);
    if (r[0]) return {1'b1, r[3:2], ~r[1]};
    return {1'b0, r[3:1]};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // Compare every observable output against the model.
  task automatic check_state();
    chk("rdy_in",   {7'd0, RDY_in},   {7'd0, (occ_m < DEPTH)});
    chk("rdy_out",  {7'd0, RDY_out},  {7'd0, (occ_m != 0)});
    chk("rdy_seed", {7'd0, RDY_seed}, {7'd0, (occ_m == 0)});
    chk("seed_err", {7'd0, seed_err}, {7'd0, err_m});
    if (occ_m != 0) chk("out_head", {4'd0, out}, {4'd0, exp_q[0]});
    else            chk("out_idle", {4'd0, out}, 8'd0);
`ifdef DESCRAMBLER_CNT_EN
    chk("count", count, 8'(cnt_m));
`endif
  endtask

  // One clock cycle of stimulus; called #1 after a rising edge.
  task automatic step(input logic ei, input logic [3:0] di, input logic eo,
                      input logic es, input logic [3:0] sv);
    logic       h_in, h_out, h_seed;
    logic [3:0] popped;
    h_in   = ei && (occ_m < DEPTH);
    h_out  = eo && (occ_m != 0);
    h_seed = es && (occ_m == 0);
    if (h_out) begin
      popped = exp_q.pop_front();
      chk("deq_data", {4'd0, out}, {4'd0, popped});
    end
    EN_in = ei; in_data = di; EN_out = eo; EN_seed = es; seed_value = sv;
    @(posedge CLK); #1;
    EN_in = 1'b0; EN_out = 1'b0; EN_seed = 1'b0;
    if (h_seed) begin
      key_m = sv;
      if (sv == 4'd0) err_m = 1'b1;
      cnt_m = 0;
    end
    if (h_in) begin
      exp_q.push_back(di ^ key_m);
      key_m = key_next(key_m);
    end
    if (h_out && cnt_m != 255) cnt_m++;
    occ_m = occ_m + int'(h_in) - int'(h_out);
    check_state();
  endtask

  task automatic enq(input logic [3:0] d);
    step(1'b1, d, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic deq();
    step(1'b0, 4'd0, 1'b1, 1'b0, 4'd0);
  endtask

  // Synchronous reset pulse, optionally with all enables held high.
  task automatic do_reset(input logic with_en);
    RST_N = 1'b0;
    EN_in = with_en; EN_out = with_en; EN_seed = with_en;
    in_data = 4'h6; seed_value = 4'h3;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    EN_in = 1'b0; EN_out = 1'b0; EN_seed = 1'b0;
    exp_q.delete();
    key_m = 4'd1; occ_m = 0; err_m = 1'b0; cnt_m = 0;
    check_state();
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    EN_in = 1'b0; EN_out = 1'b0; EN_seed = 1'b0;
    in_data = 4'd0; seed_value = 4'd0; RST_N = 1'b0;
    key_m = 4'd1; occ_m = 0; err_m = 1'b0; cnt_m = 0;
    repeat (2) @(posedge CLK);
    #1;
    do_reset(1'b0);

    // Zero stream exposes the raw keystream 1,9,D,F,E.
    for (int i = 0; i < 4; i++) enq(4'h0);
    step(1'b1, 4'h0, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 4; i++) deq();

    // Chained with the scrambler under key 1: 0xA -> 0xB -> 0xA.
    do_reset(1'b0);
    enq(4'hB);
    chk("chain_plain", {4'd0, out}, 8'h0A);
    deq();

    // Seed together with enqueue; seed while non-empty is ignored.
    step(1'b1, 4'h5, 1'b0, 1'b1, 4'h5);
    enq(4'h0);
    step(1'b0, 4'd0, 1'b0, 1'b1, 4'h3);
    deq();
    deq();
    // Dequeue while empty is ignored.
    deq();

    // Fill, overflow attempt, simultaneous enq+deq at occupancy 2.
    for (int i = 0; i < DEPTH; i++) enq(4'($urandom_range(0, 15)));
    enq(4'hC);
    deq();
    deq();
    step(1'b1, 4'($urandom_range(0, 15)), 1'b1, 1'b0, 4'd0);
    step(1'b1, 4'($urandom_range(0, 15)), 1'b1, 1'b0, 4'd0);
    deq();
    deq();

    // Pointer wrap over 12 nibbles with mixed occupancy.
    for (int i = 0; i < 12; i++) begin
      enq(4'($urandom_range(0, 15)));
      if (i % 3 != 0) deq();
    end
    while (occ_m != 0) deq();

    // Lock-up seed: keystream is 0, data passes through.
    step(1'b0, 4'd0, 1'b0, 1'b1, 4'h0);
    for (int i = 0; i < 3; i++) enq(4'($urandom_range(0, 15)));
    for (int i = 0; i < 3; i++) deq();
    do_reset(1'b0);
    enq(4'h0);
    deq();

    // Sustained throughput; counter saturation when enabled.
    enq(4'($urandom_range(0, 15)));
    for (int i = 0; i < 300; i++) step(1'b1, 4'($urandom_range(0, 15)), 1'b1, 1'b0, 4'd0);
    deq();
    step(1'b0, 4'd0, 1'b0, 1'b1, 4'h7);
    enq(4'h2);
    deq();

    // Reset mid-stream with three entries queued and enables active.
    for (int i = 0; i < 3; i++) enq(4'($urandom_range(0, 15)));
    do_reset(1'b1);
    enq(4'h0);
    chk("key_after_rst", {4'd0, out}, 8'h01);
    deq();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
